// File: rtl/avg_frame_collector_if.sv
// Stream-in / frame-out bundle of avg_frame_collector: sample handshake, eight held frame words,
// shift amount and frame counter. slave = collector side, master = producer/consumer side.
interface avg_frame_collector_if #(
    parameter int DATAWIDTH = 16,
    parameter int CNTWIDTH  = 16
);
    logic [DATAWIDTH-1:0] in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic [DATAWIDTH-1:0] a, b, c, d, e, f, g, h;
    logic [7:0]           sa;
    logic                 out_valid;
    logic                 out_ready;
    logic [CNTWIDTH-1:0]  frame_count;

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, a, b, c, d, e, f, g, h, sa, out_valid, frame_count
    );

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, a, b, c, d, e, f, g, h, sa, out_valid, frame_count
    );
endinterface

// File: rtl/avg_frame_collector.sv
// Groups a serial sample stream into 8-word frames for the averaging stage.
// Define AFC_SLIDING_WINDOW_EN for sliding-window mode (one frame per sample); default is block mode.
module avg_frame_collector #(
    parameter int DATAWIDTH = 16,
    parameter int CNTWIDTH  = 16
) (
    input  logic                  Clk,
    input  logic                  Rst,
    avg_frame_collector_if.slave  bus
);
    localparam logic [3:0] FULL = 4'd8;

    logic [DATAWIDTH-1:0] coll   [8];
    logic [DATAWIDTH-1:0] window [8];
    logic [DATAWIDTH-1:0] obank  [8];
    logic [3:0]           cnt;
    logic [3:0]           cnt_next;
    logic                 out_valid_q;
    logic [CNTWIDTH-1:0]  fc;
    logic                 in_ready_w;
    logic                 accept;
    logic                 consume;
    logic                 load;

    assign accept  = bus.in_valid && in_ready_w;
    assign consume = out_valid_q && bus.out_ready;

`ifdef AFC_SLIDING_WINDOW_EN
    logic [3:0] cnt_sat;

    assign in_ready_w = !out_valid_q || bus.out_ready;
    assign cnt_sat    = (cnt == FULL) ? FULL : cnt + 4'd1;
    // A frame leaves on the very edge that completes (or slides) the window.
    assign load       = accept && (cnt_sat == FULL);
    assign cnt_next   = accept ? cnt_sat : cnt;

    always_comb begin
        for (int i = 0; i < 7; i++) window[i] = coll[i+1];
        window[7] = bus.in_data;
    end
`else
    assign in_ready_w = (cnt != FULL);
    assign load       = (cnt == FULL) && (!out_valid_q || bus.out_ready);
    assign cnt_next   = load ? 4'd0 : (accept ? cnt + 4'd1 : cnt);

    // NOTE: every element is assigned on every path, so no latch is inferred.
    always_comb begin
        for (int i = 0; i < 8; i++) window[i] = coll[i];
    end
`endif

    // NOTE: the collect bank has no reset; cnt gates every read, so stale words never reach a..h.
    always_ff @(posedge Clk) begin
        if (accept) begin
`ifdef AFC_SLIDING_WINDOW_EN
            coll <= window;
`else
            coll[cnt[2:0]] <= bus.in_data;
`endif
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            cnt         <= 4'd0;
            out_valid_q <= 1'b0;
            fc          <= '0;
            for (int i = 0; i < 8; i++) obank[i] <= '0;
        end else begin
            cnt <= cnt_next;
            if (load) begin
                obank       <= window;
                out_valid_q <= 1'b1;
                fc          <= fc + CNTWIDTH'(1);
            end else if (consume) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready    = in_ready_w;
    assign bus.out_valid   = out_valid_q;
    assign bus.frame_count = fc;
    assign bus.sa          = 8'd1;
    assign bus.a = obank[0];
    assign bus.b = obank[1];
    assign bus.c = obank[2];
    assign bus.d = obank[3];
    assign bus.e = obank[4];
    assign bus.f = obank[5];
    assign bus.g = obank[6];
    assign bus.h = obank[7];
endmodule

// File: tb/tb_avg_frame_collector.sv
// Directed bench for avg_frame_collector: a 16-bit-counter instance plus a CNTWIDTH=2 twin
// sharing the same stimulus. Covers block mode by default, sliding-window mode when the macro is set.
module tb_avg_frame_collector;
    logic clk;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    avg_frame_collector_if #(.DATAWIDTH(16), .CNTWIDTH(16)) bus ();
    avg_frame_collector_if #(.DATAWIDTH(16), .CNTWIDTH(2))  bus_w ();

    assign bus_w.in_data   = bus.in_data;
    assign bus_w.in_valid  = bus.in_valid;
    assign bus_w.out_ready = bus.out_ready;

    avg_frame_collector #(.DATAWIDTH(16), .CNTWIDTH(16)) u_dut (
        .Clk (clk),
        .Rst (rst_n),
        .bus (bus)
    );

    avg_frame_collector #(.DATAWIDTH(16), .CNTWIDTH(2)) u_dut_w (
        .Clk (clk),
        .Rst (rst_n),
        .bus (bus_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_frame(input string tag, input logic [15:0] first, input logic [15:0] inc);
        logic [15:0] got [8];
        got = '{bus.a, bus.b, bus.c, bus.d, bus.e, bus.f, bus.g, bus.h};
        for (int i = 0; i < 8; i++)
            check($sformatf("%s_w%0d", tag, i), 32'(got[i]), 32'(16'(first + 16'(i) * inc)));
    endtask

    // Offers one sample and returns once it has been accepted (or the wait bound expires).
    task automatic send(input logic [15:0] v);
        int waits = 0;
        bus.in_data  = v;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && waits < 50) begin
            step();
            waits++;
        end
        if (waits >= 50) check("send_timeout_in_ready", 32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [18:0] sum;
        rst_n         = 1'b0;
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        #12;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_a", 32'(bus.a), 32'd0);
        check("rst_h", 32'(bus.h), 32'd0);
        check("rst_frame_count", 32'(bus.frame_count), 32'd0);
        check("rst_sa", 32'(bus.sa), 32'd1);
        rst_n = 1'b1;
        step();

`ifdef AFC_SLIDING_WINDOW_EN
        bus.out_ready = 1'b1;
        for (int v = 1; v <= 10; v++) begin
            send(16'(v));
            check($sformatf("slide_in_ready_%0d", v), 32'(bus.in_ready), 32'd1);
            if (v >= 8) begin
                check_frame($sformatf("slide_frame_%0d", v), 16'(v - 7), 16'd1);
                check($sformatf("slide_out_valid_%0d", v), 32'(bus.out_valid), 32'd1);
                check($sformatf("slide_fc_%0d", v), 32'(bus.frame_count), 32'(v - 7));
            end else begin
                check($sformatf("slide_out_valid_%0d", v), 32'(bus.out_valid), 32'd0);
            end
        end
        check("slide_fc_narrow", 32'(bus_w.frame_count), 32'd3);
        step();
        check("slide_consume_clears", 32'(bus.out_valid), 32'd0);
        check_frame("slide_held", 16'd3, 16'd1);
`else
        // Basic frame: one-cycle bubble, then frame 1..8.
        bus.out_ready = 1'b1;
        for (int v = 1; v <= 8; v++) send(16'(v));
        check("basic_bubble_in_ready", 32'(bus.in_ready), 32'd0);
        check("basic_not_yet_valid", 32'(bus.out_valid), 32'd0);
        step();
        check("basic_out_valid", 32'(bus.out_valid), 32'd1);
        check_frame("basic_frame", 16'd1, 16'd1);
        check("basic_fc", 32'(bus.frame_count), 32'd1);
        check("basic_in_ready_back", 32'(bus.in_ready), 32'd1);
        step();
        check("basic_consume_clears", 32'(bus.out_valid), 32'd0);
        check("basic_held_a", 32'(bus.a), 32'd1);

        // Backpressure: second frame waits in the collect bank.
        bus.out_ready = 1'b0;
        for (int v = 1; v <= 16; v++) send(16'(v));
        check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
        check("bp_out_valid", 32'(bus.out_valid), 32'd1);
        check_frame("bp_first", 16'd1, 16'd1);
        check("bp_fc1", 32'(bus.frame_count), 32'd2);
        repeat (3) step();
        check_frame("bp_stable", 16'd1, 16'd1);
        check("bp_still_blocked", 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check("bp_swap_out_valid", 32'(bus.out_valid), 32'd1);
        check_frame("bp_second", 16'd9, 16'd1);
        check("bp_fc2", 32'(bus.frame_count), 32'd3);
        check("bp_in_ready_free", 32'(bus.in_ready), 32'd1);

        // Asynchronous reset mid-frame.
        bus.out_ready = 1'b1;
        step();
        for (int v = 1; v <= 5; v++) send(16'(v));
        #2 rst_n = 1'b0;
        #1;
        check_frame("arst_frame", 16'd0, 16'd0);
        check("arst_out_valid", 32'(bus.out_valid), 32'd0);
        check("arst_fc", 32'(bus.frame_count), 32'd0);
        check("arst_in_ready", 32'(bus.in_ready), 32'd1);
        #1 rst_n = 1'b1;
        for (int v = 20; v <= 27; v++) send(16'(v));
        step();
        check_frame("post_rst_frame", 16'd20, 16'd1);
        check("post_rst_fc", 32'(bus.frame_count), 32'd1);

        // Idle gaps between all-ones samples.
        for (int i = 0; i < 8; i++) begin
            send(16'hFFFF);
            step();
        end
        check("gap_out_valid", 32'(bus.out_valid), 32'd1);
        check_frame("gap_frame", 16'hFFFF, 16'd0);
        check("gap_fc", 32'(bus.frame_count), 32'd2);
        sum = 19'(bus.a) + 19'(bus.b) + 19'(bus.c) + 19'(bus.d)
            + 19'(bus.e) + 19'(bus.f) + 19'(bus.g) + 19'(bus.h);
        check("gap_average", 32'(sum >> 3), 32'h0000FFFF);

        // Counter wrap on the CNTWIDTH=2 twin.
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            for (int i = 0; i < 8; i++) send(16'(k * 8 + i));
            step();
            check($sformatf("wrap_fc_narrow_%0d", k), 32'(bus_w.frame_count), 32'(k % 4));
            check($sformatf("wrap_fc_wide_%0d", k), 32'(bus.frame_count), 32'(k));
            check($sformatf("wrap_a_%0d", k), 32'(bus.a), 32'(k * 8));
            check($sformatf("wrap_h_%0d", k), 32'(bus.h), 32'(k * 8 + 7));
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/avg_frame_collector.md
# avg_frame_collector

Upstream feeder for the 8-input averaging stage. It accepts a serial stream of 16-bit samples over a valid/ready handshake and groups them into 8-sample frames. Each frame is presented as eight parallel, held words `a`..`h` together with a constant shift amount `sa`, and a valid/ready output handshake. A frame counter tracks delivered frames for debug and verification.

## Interface
- `DATAWIDTH`, 16, sample and frame word width.
- `CNTWIDTH`, 16, width of `frame_count`.
- `Clk`  in  1  rising-edge clock, the only clock.
- `Rst`  in  1  reset; asynchronous, active-low (0 = reset).
- `in_data`  in  DATAWIDTH  sample word.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  block can accept a sample this cycle.
- `a`,`b`,`c`,`d`,`e`,`f`,`g`,`h`  out  DATAWIDTH each  frame words; `a` = oldest sample, `h` = newest.
- `sa`  out  8  shift amount for the downstream ÷2 stages; constant 8'd1.
- `out_valid`  out  1  a frame is held on `a`..`h`.
- `out_ready`  in  1  downstream consumes the frame.
- `frame_count`  out  CNTWIDTH  number of frames loaded since reset.

## Operation
- **Accept:** a sample is accepted on a rising edge where `in_valid && in_ready`.
- **Collect bank:** `c0`..`c7`, written in arrival order. Fill counter `cnt` runs 0..8.
- **Output bank:** `a`..`h`, loaded only on a transfer and held otherwise. Consume is `out_valid && out_ready`.
- **Block mode (default):**
  - `in_ready = (cnt != 8)`.
  - On accept: `c[cnt] <= in_data`, `cnt <= cnt+1`.
  - Transfer occurs when `cnt == 8` and (`!out_valid || out_ready`). On transfer: `a..h <= c0..c7`, `out_valid <= 1`, `cnt <= 0`, `frame_count <= frame_count+1`.
  - Frames do not overlap.
- **out_valid clear:** `out_valid` goes to 0 on a consume with no transfer in the same cycle. A consume and a transfer in the same cycle keep `out_valid` at 1 and load the new frame.
- **frame_count:** wraps modulo 2^CNTWIDTH.
- **Reset (Rst = 0, any time, including mid-frame):**
  - `cnt = 0`; partial frame discarded.
  - `out_valid = 0`, `a`..`h = 0`, `frame_count = 0`.
  - `in_ready = 1`, `sa = 1`.

## Timing
- **Block-mode latency:** 8th sample accepted at edge k → `cnt == 8` during cycle k → `out_valid = 1` and frame visible after edge k+1 (if the output bank is free).
- **Bubble:** `in_ready` is low for the transfer cycle. Peak throughput is 8 samples per 9 cycles.
- **Backpressure:** while `cnt == 8` and a frame is held with `out_ready = 0`, `in_ready` stays 0 and `c0..c7` hold.
- **Output stability:** `a`..`h` change only on a transfer edge, and are stable while `out_valid && !out_ready`.
- **Downstream sampling:** `sa` is combinationally constant. The downstream register samples `a`..`h` one edge after a consume; the held values guarantee this.

## Configuration
- **Macro:** `AFC_SLIDING_WINDOW_EN`.
- **Defined (sliding-window mode):**
  - `c0..c7` form a shift register: on accept, `c0 <= c1`, …, `c6 <= c7`, `c7 <= in_data`.
  - `cnt` saturates at 8.
  - `in_ready = !out_valid || out_ready`.
  - Transfer happens on the same accept edge whenever the post-accept `cnt == 8`: `a..h <=` the new window (`a` = oldest).
  - Result: one frame per sample after the first 7 samples, with 1-edge latency.
  - Reset clears `cnt`, so a full 8-sample refill is required.
- **Undefined:** block mode as described in Operation.

## Test plan
- **Basic frame:** after reset, stream 1..8 with `in_valid = 1`, `out_ready = 1` → `out_valid` rises one edge after the 8th accept; `a = 1` … `h = 8`; `frame_count = 1`; `in_ready` low for exactly one cycle.
- **Backpressure:** stream 1..16 with `out_ready = 0` → first frame 1..8 held stable. `in_ready` drops after sample 16. Raising `out_ready` for one cycle → next edge shows `a = 9` … `h = 16`, `out_valid` still 1, `frame_count = 2`.
- **Reset mid-frame:** accept 1..5, pulse `Rst = 0` between edges (asynchronous) → all outputs 0 immediately. Then stream 20..27 → frame `a = 20` … `h = 27`.
- **Idle gaps:** `in_valid` toggling every other cycle across 8 samples 0xFFFF → frame of all 0xFFFF. Downstream average = 0xFFFF.
- **Counter wrap:** with `CNTWIDTH = 2`, deliver 5 frames → `frame_count` sequence 1, 2, 3, 0, 1.
- **Sliding window (`AFC_SLIDING_WINDOW_EN`):** stream 1..10 with `out_ready = 1` → frames (1..8), (2..9), (3..10) on consecutive edges starting at the 8th accept. `frame_count = 3`. `in_ready` stays 1 throughout.
